// File: rtl/decode_pkg.sv
// Shared RV32I decode types: opcode map, instruction formats and the
// registered bundle handed to the register-file/execute stage.
package decode_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int PC_W   = 32;

  localparam logic [6:0] OP_LUI      = 7'b0110111;
  localparam logic [6:0] OP_AUIPC    = 7'b0010111;
  localparam logic [6:0] OP_JAL      = 7'b1101111;
  localparam logic [6:0] OP_JALR     = 7'b1100111;
  localparam logic [6:0] OP_BRANCH   = 7'b1100011;
  localparam logic [6:0] OP_LOAD     = 7'b0000011;
  localparam logic [6:0] OP_STORE    = 7'b0100011;
  localparam logic [6:0] OP_IMM      = 7'b0010011;
  localparam logic [6:0] OP_OP       = 7'b0110011;
  localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [XLEN-1:0]   imm;
    fmt_e              fmt;
    logic              uses_rs1;
    logic              uses_rs2;
    logic              illegal;
  } dec_bundle_t;

endpackage

// File: rtl/decode_if.sv
// Fetch-side and execute-side handshakes of the decode stage in one bundle.
// slave = the decode stage, master = whoever drives fetch and consumes decode.
interface decode_if
  import decode_pkg::*;
#(
  parameter int INSTR_WIDTH   = 32,
  parameter int ADDRESS_WIDTH = 5,
  parameter int PC_WIDTH      = 32
);
  logic                     flush;
  logic                     in_valid;
  logic                     in_ready;
  logic [INSTR_WIDTH-1:0]   instr;
  logic [PC_WIDTH-1:0]      pc_in;
  logic                     out_valid;
  logic                     out_ready;
  logic [PC_WIDTH-1:0]      pc_out;
  logic [ADDRESS_WIDTH-1:0] rs1;
  logic [ADDRESS_WIDTH-1:0] rs2;
  logic [ADDRESS_WIDTH-1:0] rd;
  logic [6:0]               opcode;
  logic [2:0]               funct3;
  logic [6:0]               funct7;
  logic [31:0]              imm;
  fmt_e                     fmt;
  logic                     uses_rs1;
  logic                     uses_rs2;
  logic                     illegal;

  modport slave (
    input  flush, in_valid, instr, pc_in, out_ready,
    output in_ready, out_valid, pc_out, rs1, rs2, rd, opcode, funct3, funct7,
           imm, fmt, uses_rs1, uses_rs2, illegal
  );

  modport master (
    output flush, in_valid, instr, pc_in, out_ready,
    input  in_ready, out_valid, pc_out, rs1, rs2, rd, opcode, funct3, funct7,
           imm, fmt, uses_rs1, uses_rs2, illegal
  );
endinterface

// File: rtl/decode_stage_imm_gen.sv
// Combinational format classifier and immediate extractor for one RV32I word.
module imm_gen
  import decode_pkg::*;
(
  input  logic [31:0] instr,
  output logic [31:0] imm,
  output fmt_e        fmt,
  output logic        illegal,
  output logic        uses_rs1,
  output logic        uses_rs2
);

  always_comb begin
    imm     = '0;
    fmt     = FMT_R;
    illegal = 1'b0;
    unique case (instr[6:0])
      OP_LUI, OP_AUIPC: begin
        fmt = FMT_U;
        imm = {instr[31:12], 12'b0};
      end
      OP_JAL: begin
        fmt = FMT_J;
        imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      OP_JALR, OP_LOAD, OP_IMM, OP_MISC_MEM, OP_SYSTEM: begin
        fmt = FMT_I;
        imm = {{20{instr[31]}}, instr[31:20]};
      end
      OP_STORE: begin
        fmt = FMT_S;
        imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      end
      OP_BRANCH: begin
        fmt = FMT_B;
        imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      end
      OP_OP:   fmt = FMT_R;
      default: illegal = 1'b1;
    endcase
  end

  // Operand reads follow the format; an unrecognised opcode reads nothing.
  always_comb begin
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    if (!illegal) begin
      unique case (fmt)
        FMT_R, FMT_S, FMT_B: begin
          uses_rs1 = 1'b1;
          uses_rs2 = 1'b1;
        end
        FMT_I:   uses_rs1 = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Registered RV32I decode stage with a 2-entry skid buffer; in_ready is a
// state flop bit so out_ready never reaches it combinationally.
module decode_stage
  import decode_pkg::*;
(
  input logic     clk,
  input logic     rst_n,
  decode_if.slave bus
);

  // in_ready is ~state[1], out_valid is |state.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    TWO   = 2'b10
  } state_e;

  state_e      state, state_nx;
  dec_bundle_t dec, out_q, skid_q;
  logic        in_rdy, out_vld, in_xfer, out_xfer;
  logic [31:0] imm;
  fmt_e        fmt;
  logic        illegal, uses_rs1, uses_rs2;

  imm_gen u_imm_gen (
    .instr    (bus.instr),
    .imm      (imm),
    .fmt      (fmt),
    .illegal  (illegal),
    .uses_rs1 (uses_rs1),
    .uses_rs2 (uses_rs2)
  );

  always_comb begin
    dec          = '0;
    dec.pc       = bus.pc_in;
    dec.rs1      = bus.instr[19:15];
    dec.rs2      = bus.instr[24:20];
    dec.rd       = bus.instr[11:7];
    dec.opcode   = bus.instr[6:0];
    dec.funct3   = bus.instr[14:12];
    dec.funct7   = bus.instr[31:25];
    dec.imm      = imm;
    dec.fmt      = fmt;
    dec.uses_rs1 = uses_rs1;
    dec.uses_rs2 = uses_rs2;
    dec.illegal  = illegal;
  end

  // A flushed input never counts as a transfer, even with in_ready high.
  assign in_xfer  = bus.in_valid & in_rdy & ~bus.flush;
  assign out_xfer = out_vld & bus.out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (bus.flush) begin
      state_nx = EMPTY;
    end else begin
      unique case (state)
        EMPTY: if (in_xfer) state_nx = ONE;
        ONE: begin
          if (in_xfer && !out_xfer)      state_nx = TWO;
          else if (!in_xfer && out_xfer) state_nx = EMPTY;
        end
        TWO:     if (out_xfer) state_nx = ONE;
        default: state_nx = EMPTY;
      endcase
    end
  end

  always_comb begin
    in_rdy  = ~state[1];
    out_vld = state[0] | state[1];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q  <= '0;
      skid_q <= '0;
    end else begin
      if (in_xfer && (state == EMPTY || (state == ONE && out_xfer)))
        out_q <= dec;
      else if (state == TWO && out_xfer)
        out_q <= skid_q;
      if (in_xfer && state == ONE && !out_xfer)
        skid_q <= dec;
    end
  end

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = out_vld;
  assign bus.pc_out    = out_q.pc;
  assign bus.rs1       = out_q.rs1;
  assign bus.rs2       = out_q.rs2;
  assign bus.rd        = out_q.rd;
  assign bus.opcode    = out_q.opcode;
  assign bus.funct3    = out_q.funct3;
  assign bus.funct7    = out_q.funct7;
  assign bus.imm       = out_q.imm;
  assign bus.fmt       = out_q.fmt;
  assign bus.uses_rs1  = out_q.uses_rs1;
  assign bus.uses_rs2  = out_q.uses_rs2;
  assign bus.illegal   = out_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: an occupancy/queue model checked every
// cycle, plus literal expectations for the documented example instructions.
module tb_decode_stage;
  import decode_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic model_on = 1'b0;
  int   checks = 0;
  int   failures = 0;
  logic [101:0] q[$];

  decode_if bus ();

  decode_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  // Expected bundle from the ISA field layout, built with shifts and masks.
  function automatic logic [101:0] model(input logic [31:0] i, input logic [31:0] pc);
    logic signed [31:0] s, sh11, sh19, sh20;
    logic [31:0] imm;
    logic [2:0]  f;
    logic        u1, u2, ill;
    s    = i;
    sh11 = s >>> 11;
    sh19 = s >>> 19;
    sh20 = s >>> 20;
    imm  = 32'h0;
    f    = 3'd0;
    ill  = 1'b0;
    case (i[6:0])
      7'h37, 7'h17: begin f = 3'd4; imm = i & 32'hFFFFF000; end
      7'h6F: begin
        f = 3'd5;
        imm = (sh11 & 32'hFFF00000) | (i & 32'h000FF000) | ((i >> 9) & 32'h800) | ((i >> 20) & 32'h7FE);
      end
      7'h67, 7'h03, 7'h13, 7'h0F, 7'h73: begin f = 3'd1; imm = sh20; end
      7'h23: begin f = 3'd2; imm = (sh20 & ~32'h1F) | ((i >> 7) & 32'h1F); end
      7'h63: begin
        f = 3'd3;
        imm = (sh19 & 32'hFFFFF000) | ((i << 4) & 32'h800) | ((i >> 20) & 32'h7E0) | ((i >> 7) & 32'h1E);
      end
      7'h33:   f = 3'd0;
      default: ill = 1'b1;
    endcase
    u1 = !ill && (f <= 3'd3);
    u2 = !ill && (f == 3'd0 || f == 3'd2 || f == 3'd3);
    return {pc, i[19:15], i[24:20], i[11:7], i[6:0], i[14:12], i[31:25], imm, f, u1, u2, ill};
  endfunction

  function automatic logic [101:0] dut_vec();
    return {bus.pc_out, bus.rs1, bus.rs2, bus.rd, bus.opcode, bus.funct3, bus.funct7,
            bus.imm, 3'(bus.fmt), bus.uses_rs1, bus.uses_rs2, bus.illegal};
  endfunction

  // Compare against the model, then advance it for the coming edge.
  always @(negedge clk) begin
    if (model_on) begin
      logic acc;
      chk("out_valid", bus.out_valid, 128'(q.size() > 0));
      chk("in_ready", bus.in_ready, 128'(q.size() < 2));
      if (q.size() > 0 && bus.out_valid) chk("bundle", dut_vec(), q[0]);
      if (!rst_n || bus.flush) begin
        q.delete();
      end else begin
        acc = bus.in_valid && (q.size() < 2);
        if (bus.out_ready && q.size() > 0) void'(q.pop_front());
        if (acc) q.push_back(model(bus.instr, bus.pc_in));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; holds the word until it is accepted.
  task automatic send(input logic [31:0] i, input logic [31:0] pc);
    logic done;
    done = 1'b0;
    bus.in_valid = 1'b1;
    bus.instr    = i;
    bus.pc_in    = pc;
    for (int n = 0; n < 20 && !done; n++) begin
      @(negedge clk);
      done = bus.in_ready;
      tick();
    end
    bus.in_valid = 1'b0;
    if (!done) chk("send_timeout", done, 1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, bus.out_valid, 0);
    chk({tag, "_in_ready"}, bus.in_ready, 1);
    chk({tag, "_bundle"}, dut_vec(), 0);
  endtask

  initial begin
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b1;
    bus.instr     = 32'h00500093;
    bus.pc_in     = 32'hDEAD0000;
    bus.out_ready = 1'b1;
    tick();
    model_on = 1'b1;
    tick();
    tick();
    rst_n        = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk_reset_outputs("reset");
    tick();

    // Single instructions with a free downstream.
    send(32'hFFF00093, 32'h100);
    @(negedge clk);
    chk("addi_valid", bus.out_valid, 1);
    chk("addi_rd", bus.rd, 1);
    chk("addi_rs1", bus.rs1, 0);
    chk("addi_opcode", bus.opcode, 7'h13);
    chk("addi_fmt", bus.fmt, FMT_I);
    chk("addi_imm", bus.imm, 32'hFFFFFFFF);
    chk("addi_uses", {bus.uses_rs1, bus.uses_rs2}, 2'b10);
    tick();
    send(32'h0020A423, 32'h104);
    @(negedge clk);
    chk("sw_fmt", bus.fmt, FMT_S);
    chk("sw_imm", bus.imm, 32'h00000008);
    chk("sw_uses", {bus.uses_rs1, bus.uses_rs2}, 2'b11);
    tick();
    send(32'hFE000EE3, 32'h108);
    @(negedge clk);
    chk("beq_fmt", bus.fmt, FMT_B);
    chk("beq_imm", bus.imm, 32'hFFFFFFFC);
    tick();
    send(32'h123452B7, 32'h10C);
    @(negedge clk);
    chk("lui_fmt", bus.fmt, FMT_U);
    chk("lui_imm", bus.imm, 32'h12345000);
    chk("lui_rd", bus.rd, 5);
    chk("lui_uses", {bus.uses_rs1, bus.uses_rs2}, 2'b00);
    tick();
    send(32'hFF9FF0EF, 32'h110);
    @(negedge clk);
    chk("jal_fmt", bus.fmt, FMT_J);
    chk("jal_imm", bus.imm, 32'hFFFFFFF8);
    tick();
    send(32'h00000000, 32'h114);
    @(negedge clk);
    chk("zero_illegal", bus.illegal, 1);
    chk("zero_imm", bus.imm, 0);
    chk("zero_fmt", bus.fmt, FMT_R);
    chk("zero_uses", {bus.uses_rs1, bus.uses_rs2}, 2'b00);
    tick();

    // Back-to-back stream at full rate.
    begin
      logic [31:0] stream [6];
      stream = '{32'h00008067, 32'h002081B3, 32'h00001517, 32'h30002573,
                 32'h0000000F, 32'hFFC12083};
      for (int k = 0; k < 6; k++) begin
        bus.in_valid = 1'b1;
        bus.instr    = stream[k];
        bus.pc_in    = 32'h200 + 32'(k * 4);
        @(negedge clk);
        chk("stream_in_ready", bus.in_ready, 1);
        tick();
      end
      bus.in_valid = 1'b0;
      tick();
    end

    // Backpressure: third word must wait until the skid entry drains.
    bus.out_ready = 1'b0;
    send(32'h00100113, 32'h300);
    send(32'h00200193, 32'h304);
    bus.in_valid = 1'b1;
    bus.instr    = 32'h00300213;
    bus.pc_in    = 32'h308;
    @(negedge clk);
    chk("bp_in_ready", bus.in_ready, 0);
    tick();
    @(negedge clk);
    chk("bp_hold_pc", bus.pc_out, 32'h300);
    chk("bp_hold_valid", bus.out_valid, 1);
    tick();
    bus.out_ready = 1'b1;
    send(32'h00300213, 32'h308);
    repeat (3) tick();

    // Flush while full, with a word offered in the same cycle.
    bus.out_ready = 1'b0;
    send(32'h00400293, 32'h400);
    send(32'h00500313, 32'h404);
    bus.in_valid = 1'b1;
    bus.instr    = 32'h00600393;
    bus.pc_in    = 32'h408;
    bus.flush    = 1'b1;
    tick();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("flush_out_valid", bus.out_valid, 0);
    chk("flush_in_ready", bus.in_ready, 1);
    repeat (3) tick();

    // Reset while an output is pending.
    bus.out_ready = 1'b0;
    send(32'h00700413, 32'h500);
    @(negedge clk);
    chk("prerst_valid", bus.out_valid, 1);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset_outputs("midrst");
    tick();
    bus.out_ready = 1'b1;
    send(32'h00800493, 32'h504);
    @(negedge clk);
    chk("postrst_valid", bus.out_valid, 1);
    chk("postrst_pc", bus.pc_out, 32'h504);
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
